// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests,
// an in-order response buffer and stale-response draining on redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   localparam logic [1:0] INIT  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic [1:0]    state;
   logic [31:0]   pcQ;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] dropCnt;
   logic [CW-1:0] count;
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;
   entry_t        bufMem [DEPTH];

   logic          reqFire;
   logic          rspTake;
   logic          push;
   logic          pop;
   logic          bufValid;
   logic [CW:0]   credits;
   logic [CW-1:0] outsAfterRsp;
   logic [31:0]   rspPc;
   logic [31:0]   redirectPc;

   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Handshake qualifiers, credit check and oldest in-flight PC
   always_comb begin
      bufValid     = (count != '0);
      credits      = {1'b0, count} + {1'b0, outstanding};
      rspTake      = imem_rsp_valid && (outstanding != '0);
      outsAfterRsp = outstanding - CW'(rspTake);
      rspPc        = pcQ - 32'({outstanding, 2'b00});
      redirectPc   = redirect_target & 32'hFFFF_FFFC;
      imem_req_valid = (state == RUN) && !redirect_valid
                       && (credits < DEPTH_C);
      reqFire      = imem_req_valid && imem_req_ready;
      push         = rspTake && (state == RUN) && !redirect_valid;
      pop          = bufValid && id_ready;
      imem_addr    = pcQ;
      id_valid     = bufValid;
      id_instr     = bufValid ? bufMem[rdPtr].instr : '0;
      id_pc        = bufValid ? bufMem[rdPtr].pc : '0;
   end

   // Control state, fetch PC and count of stale responses to drop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= INIT;
         pcQ     <= RESET_PC;
         dropCnt <= '0;
      end else if (redirect_valid) begin
         pcQ     <= redirectPc;
         dropCnt <= outsAfterRsp;
         state   <= (outsAfterRsp != '0) ? DRAIN : RUN;
      end else begin
         if (reqFire) begin
            pcQ <= pcQ + 32'd4;
         end
         case (state)
            INIT: state <= RUN;
            RUN:  state <= RUN;
            DRAIN: begin
               if (dropCnt == '0) begin
                  state <= RUN;
               end else if (rspTake) begin
                  dropCnt <= dropCnt - CW'(1);
                  if (dropCnt == CW'(1)) begin
                     state <= RUN;
                  end
               end
            end
            default: state <= INIT;
         endcase
      end
   end

   // Requests in flight; a redirect never coincides with an accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         outstanding <= outstanding + CW'(reqFire) - CW'(rspTake);
      end
   end

   // Buffer pointers and occupancy; redirect flushes the buffer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (redirect_valid) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= nextPtr(wrPtr);
         end
         if (pop) begin
            rdPtr <= nextPtr(rdPtr);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Buffer storage: instruction word tagged with its fetch PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            bufMem[i] <= '0;
         end
      end else if (push) begin
         bufMem[wrPtr] <= '{pc: rspPc, instr: imem_rsp_data};
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit streaming, stall,
// redirect/drain, wrap and reset behaviour.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reqReady;
   logic        ready3;
   logic        rspValid;
   logic [31:0] rspData;
   logic        idReady;
   logic        redirValid;
   logic [31:0] redirTarget;
   logic        reqValid;
   logic [31:0] addr;
   logic        idValid;
   logic [31:0] idInstr;
   logic [31:0] idPc;
   logic        d3ReqValid;
   logic [31:0] d3Addr;
   logic        d3IdValid;
   logic [31:0] d3IdInstr;
   logic [31:0] d3IdPc;
   logic        autoMem;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(reqValid), .imem_req_ready(reqReady),
      .imem_addr(addr),
      .imem_rsp_valid(rspValid), .imem_rsp_data(rspData),
      .id_valid(idValid), .id_ready(idReady),
      .id_instr(idInstr), .id_pc(idPc),
      .redirect_valid(redirValid), .redirect_target(redirTarget)
   );

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(d3ReqValid), .imem_req_ready(ready3),
      .imem_addr(d3Addr),
      .imem_rsp_valid(rspValid), .imem_rsp_data(rspData),
      .id_valid(d3IdValid), .id_ready(idReady),
      .id_instr(d3IdInstr), .id_pc(d3IdPc),
      .redirect_valid(redirValid), .redirect_target(redirTarget)
   );

   // One clock; optional 1-cycle memory answers with addr ^ DEAD0000
   task automatic tick();
      logic f;
      logic [31:0] a;
      @(negedge clk);
      f = reqValid && reqReady;
      a = addr;
      @(posedge clk);
      #1;
      if (autoMem) begin
         rspValid = f;
         rspData  = f ? (a ^ 32'hDEAD_0000) : 32'h0;
      end
      #1;
   endtask

   task automatic idle();
      reqReady = 1'b0;
      ready3 = 1'b0;
      idReady = 1'b1;
      redirValid = 1'b0;
      autoMem = 1'b1;
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      reqReady = 1'b0; ready3 = 1'b0; rspValid = 1'b0;
      rspData = 32'h0; idReady = 1'b0; redirValid = 1'b0;
      redirTarget = 32'h0; autoMem = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      total++; if (reqValid !== 1'b0) begin bad++;
         $display("FAIL rst_req_valid got=%0h want=0", reqValid); end
      total++; if (idValid !== 1'b0) begin bad++;
         $display("FAIL rst_id_valid got=%0h want=0", idValid); end
      total++; if (addr !== 32'h0) begin bad++;
         $display("FAIL rst_addr got=%h want=00000000", addr); end
      total++; if (idInstr !== 32'h0) begin bad++;
         $display("FAIL rst_id_instr got=%h want=00000000", idInstr); end
      total++; if (idPc !== 32'h0) begin bad++;
         $display("FAIL rst_id_pc got=%h want=00000000", idPc); end
      tick();
      tick();
      rst_n = 1'b1; reqReady = 1'b1; idReady = 1'b1;
      #1;
      total++; if (reqValid !== 1'b0) begin bad++;
         $display("FAIL init_no_req got=%0h want=0", reqValid); end
      tick();
      total++; if (reqValid !== 1'b1) begin bad++;
         $display("FAIL run_req_valid got=%0h want=1", reqValid); end
      total++; if (addr !== 32'h0) begin bad++;
         $display("FAIL run_first_addr got=%h want=00000000", addr); end
   endtask

   task automatic test_stream();
      logic [31:0] iss[$];
      logic [31:0] ppc[$];
      logic [31:0] pins[$];
      for (int i = 0; i < 10; i++) begin
         if (reqValid && reqReady) iss.push_back(addr);
         if (idValid && idReady) begin
            ppc.push_back(idPc);
            pins.push_back(idInstr);
         end
         tick();
      end
      total++;
      if (iss.size() < 3 || ppc.size() < 3) begin
         bad++;
         $display("FAIL stream_count got=%0d/%0d want>=3/3",
                  iss.size(), ppc.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            total++; if (iss[k] !== 32'(k * 4)) begin bad++;
               $display("FAIL stream_addr%0d got=%h want=%h",
                        k, iss[k], 32'(k * 4)); end
            total++; if (ppc[k] !== 32'(k * 4)) begin bad++;
               $display("FAIL stream_pc%0d got=%h want=%h",
                        k, ppc[k], 32'(k * 4)); end
            total++;
            if (pins[k] !== (32'hDEAD_0000 | 32'(k * 4))) begin bad++;
               $display("FAIL stream_instr%0d got=%h want=%h", k,
                        pins[k], 32'hDEAD_0000 | 32'(k * 4)); end
         end
      end
      idle();
   endtask

   task automatic test_stall();
      int n;
      redirValid = 1'b1; redirTarget = 32'h0000_0203;
      #1;
      total++; if (reqValid !== 1'b0) begin bad++;
         $display("FAIL redir_blocks_req got=%0h want=0", reqValid); end
      tick();
      redirValid = 1'b0; reqReady = 1'b1; idReady = 1'b0;
      #1;
      total++; if (addr !== 32'h0000_0200) begin bad++;
         $display("FAIL redir_mask_addr got=%h want=00000200", addr); end
      n = 0;
      for (int i = 0; i < 5; i++) begin
         if (reqValid && reqReady) n++;
         if (i >= 2) begin
            total++;
            if (idValid !== 1'b1 || idInstr !== 32'hDEAD_0200
                || idPc !== 32'h200) begin bad++;
               $display("FAIL stall_hold%0d got=%0h/%h/%h want=1/dead0200/00000200",
                        i, idValid, idInstr, idPc); end
            total++; if (reqValid !== 1'b0) begin bad++;
               $display("FAIL stall_no_req%0d got=%0h want=0", i, reqValid); end
         end
         tick();
      end
      total++; if (n !== 2) begin bad++;
         $display("FAIL stall_req_count got=%0d want=2", n); end
      idReady = 1'b1;
      #1;
      total++; if (idPc !== 32'h200) begin bad++;
         $display("FAIL stall_pop0 got=%h want=00000200", idPc); end
      tick();
      total++; if (idPc !== 32'h204 || idInstr !== 32'hDEAD_0204) begin bad++;
         $display("FAIL stall_pop1 got=%h/%h want=00000204/dead0204",
                  idPc, idInstr); end
      total++; if (reqValid !== 1'b1 || addr !== 32'h208) begin bad++;
         $display("FAIL stall_resume got=%0h/%h want=1/00000208",
                  reqValid, addr); end
      idle();
   endtask

   task automatic test_redirect_drain();
      autoMem = 1'b0; rspValid = 1'b0;
      redirValid = 1'b1; redirTarget = 32'h40;
      tick();
      redirValid = 1'b0; reqReady = 1'b1; idReady = 1'b1;
      #1;
      total++; if (addr !== 32'h40) begin bad++;
         $display("FAIL drain_setup_addr got=%h want=00000040", addr); end
      tick();
      tick();
      total++; if (reqValid !== 1'b0) begin bad++;
         $display("FAIL credit_full got=%0h want=0", reqValid); end
      redirValid = 1'b1; redirTarget = 32'h100;
      #1;
      tick();
      redirValid = 1'b0;
      #1;
      total++; if (reqValid !== 1'b0 || addr !== 32'h100) begin bad++;
         $display("FAIL drain_enter got=%0h/%h want=0/00000100",
                  reqValid, addr); end
      rspValid = 1'b1; rspData = 32'h0BAD_0040;
      tick();
      total++; if (reqValid !== 1'b0 || idValid !== 1'b0) begin bad++;
         $display("FAIL drain_mid got=%0h/%0h want=0/0",
                  reqValid, idValid); end
      rspData = 32'h0BAD_0044;
      tick();
      rspValid = 1'b0;
      #1;
      total++; if (idValid !== 1'b0) begin bad++;
         $display("FAIL drain_discard got=%0h want=0", idValid); end
      total++; if (reqValid !== 1'b1 || addr !== 32'h100) begin bad++;
         $display("FAIL drain_exit got=%0h/%h want=1/00000100",
                  reqValid, addr); end
      autoMem = 1'b1;
      tick();
      tick();
      total++;
      if (idValid !== 1'b1 || idPc !== 32'h100
          || idInstr !== 32'hDEAD_0100) begin bad++;
         $display("FAIL drain_first_pc got=%0h/%h/%h want=1/00000100/dead0100",
                  idValid, idPc, idInstr); end
      idle();
   endtask

   task automatic test_spurious();
      autoMem = 1'b0; reqReady = 1'b0;
      rspValid = 1'b1; rspData = 32'h1234_5678;
      tick();
      rspValid = 1'b0;
      #1;
      total++; if (idValid !== 1'b0) begin bad++;
         $display("FAIL spurious_push got=%0h want=0", idValid); end
      total++; if (reqValid !== 1'b1) begin bad++;
         $display("FAIL spurious_credit got=%0h want=1", reqValid); end
      idle();
   endtask

   task automatic test_same_cycle();
      autoMem = 1'b0; rspValid = 1'b0; reqReady = 1'b0;
      ready3 = 1'b0; idReady = 1'b1;
      redirValid = 1'b1; redirTarget = 32'h300;
      tick();
      redirValid = 1'b0; ready3 = 1'b1;
      #1;
      total++; if (d3ReqValid !== 1'b1 || d3Addr !== 32'h300) begin bad++;
         $display("FAIL sc_setup got=%0h/%h want=1/00000300",
                  d3ReqValid, d3Addr); end
      tick();
      tick();
      rspValid = 1'b1; rspData = 32'hC0DE_0300;
      #1;
      total++; if (d3ReqValid !== 1'b1 || d3Addr !== 32'h308) begin bad++;
         $display("FAIL sc_third_req got=%0h/%h want=1/00000308",
                  d3ReqValid, d3Addr); end
      tick();
      ready3 = 1'b0; rspValid = 1'b0;
      #1;
      total++;
      if (d3IdValid !== 1'b1 || d3IdPc !== 32'h300
          || d3IdInstr !== 32'hC0DE_0300) begin bad++;
         $display("FAIL sc_head got=%0h/%h/%h want=1/00000300/c0de0300",
                  d3IdValid, d3IdPc, d3IdInstr); end
      redirValid = 1'b1; redirTarget = 32'h400;
      rspValid = 1'b1; rspData = 32'hC0DE_0304;
      #1;
      tick();
      redirValid = 1'b0; rspValid = 1'b0;
      #1;
      total++; if (d3IdValid !== 1'b0) begin bad++;
         $display("FAIL sc_flush got=%0h want=0", d3IdValid); end
      total++; if (d3ReqValid !== 1'b0) begin bad++;
         $display("FAIL sc_drain got=%0h want=0", d3ReqValid); end
      tick();
      total++; if (d3ReqValid !== 1'b0) begin bad++;
         $display("FAIL sc_drain_hold got=%0h want=0", d3ReqValid); end
      rspValid = 1'b1; rspData = 32'hC0DE_0308;
      tick();
      rspValid = 1'b0;
      #1;
      total++;
      if (d3ReqValid !== 1'b1 || d3Addr !== 32'h400
          || d3IdValid !== 1'b0) begin bad++;
         $display("FAIL sc_drop_one got=%0h/%h/%0h want=1/00000400/0",
                  d3ReqValid, d3Addr, d3IdValid); end
      idle();
   endtask

   task automatic test_wrap();
      autoMem = 1'b1; reqReady = 1'b0;
      redirValid = 1'b1; redirTarget = 32'hFFFF_FFFF;
      tick();
      redirValid = 1'b0; reqReady = 1'b1; idReady = 1'b1;
      #1;
      total++; if (reqValid !== 1'b1 || addr !== 32'hFFFF_FFFC) begin bad++;
         $display("FAIL wrap_top got=%0h/%h want=1/fffffffc",
                  reqValid, addr); end
      tick();
      total++; if (addr !== 32'h0) begin bad++;
         $display("FAIL wrap_zero got=%h want=00000000", addr); end
      tick();
      total++;
      if (idValid !== 1'b1 || idPc !== 32'hFFFF_FFFC
          || idInstr !== 32'h2152_FFFC) begin bad++;
         $display("FAIL wrap_id got=%0h/%h/%h want=1/fffffffc/2152fffc",
                  idValid, idPc, idInstr); end
      idle();
   endtask

   task automatic test_reset_mid();
      autoMem = 1'b0; rspValid = 1'b0; reqReady = 1'b0;
      redirValid = 1'b1; redirTarget = 32'h500;
      tick();
      redirValid = 1'b0; reqReady = 1'b1; idReady = 1'b0;
      #1;
      tick();
      rspValid = 1'b1; rspData = 32'hAAAA_0500;
      #1;
      tick();
      rspValid = 1'b0;
      #1;
      total++; if (idValid !== 1'b1 || idPc !== 32'h500) begin bad++;
         $display("FAIL rm_pre got=%0h/%h want=1/00000500", idValid, idPc); end
      rst_n = 1'b0;
      #1;
      total++; if (reqValid !== 1'b0 || idValid !== 1'b0) begin bad++;
         $display("FAIL rm_valids got=%0h/%0h want=0/0", reqValid, idValid); end
      total++; if (addr !== 32'h0) begin bad++;
         $display("FAIL rm_addr got=%h want=00000000", addr); end
      total++; if (idInstr !== 32'h0 || idPc !== 32'h0) begin bad++;
         $display("FAIL rm_id got=%h/%h want=00000000/00000000",
                  idInstr, idPc); end
      rspValid = 1'b1; rspData = 32'hBBBB_0504;
      tick();
      rst_n = 1'b1;
      #1;
      total++; if (reqValid !== 1'b0 || addr !== 32'h0) begin bad++;
         $display("FAIL rm_init got=%0h/%h want=0/00000000", reqValid, addr); end
      tick();
      total++; if (idValid !== 1'b0) begin bad++;
         $display("FAIL rm_late_rsp got=%0h want=0", idValid); end
      total++; if (reqValid !== 1'b1 || addr !== 32'h0) begin bad++;
         $display("FAIL rm_restart got=%0h/%h want=1/00000000",
                  reqValid, addr); end
      rspValid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drain();
      test_spurious();
      test_same_cycle();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
